// File: rtl/dtc_pkg.sv
// Shared symbol type codes, field widths and FSM encodings for the DTC master link.
package dtc_pkg;

    localparam logic [1:0] TYPE_L0  = 2'b00;
    localparam logic [1:0] TYPE_L1  = 2'b01;
    localparam logic [1:0] TYPE_CMD = 2'b10;

    localparam int CMD_W = 32;
    localparam int RSP_W = 16;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_HDR,
        TX_PAYLOAD,
        TX_PARITY,
        TX_GAP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_WAIT,
        RX_DATA,
        RX_PAR
    } rx_state_t;

endpackage

// File: rtl/dtc_master_rsp_rx.sv
// Response receiver: waits for a start bit on dtc_return after a command,
// shifts in the 16-bit reply, checks even parity and reports timeouts.
module dtc_master_rsp_rx
    import dtc_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic             rdoclk,
    input  logic             reset,
    input  logic             start,
    input  logic             dtc_return,
    output logic             rsp_valid,
    output logic [RSP_W-1:0] rsp_data,
    output logic             rsp_err,
    output logic             rsp_timeout
);

    localparam int TMO_W = $clog2(TIMEOUT + 2);

    rx_state_t        state, state_next;
    logic             ret_q;
    logic [TMO_W-1:0] tmo_cnt;
    logic [3:0]       bit_cnt;
    logic [RSP_W-1:0] shift;
    logic             start_seen;
    logic             tmo_hit;

    // The start bit wins over the timeout on the last allowed count.
    assign start_seen = (state == RX_WAIT) && ret_q;
    assign tmo_hit    = (state == RX_WAIT) && !ret_q && (tmo_cnt == TMO_W'(TIMEOUT));

    always_comb begin
        state_next = state;
        case (state)
            RX_IDLE:  if (start) state_next = RX_WAIT;
            RX_WAIT: begin
                if (start_seen)   state_next = RX_DATA;
                else if (tmo_hit) state_next = RX_IDLE;
            end
            RX_DATA:  if (bit_cnt == 4'(RSP_W - 1)) state_next = RX_PAR;
            RX_PAR:   state_next = RX_IDLE;
            default:  state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge rdoclk) begin
        if (reset) begin
            state       <= RX_IDLE;
            ret_q       <= 1'b0;
            tmo_cnt     <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state     <= state_next;
            ret_q     <= dtc_return;
            rsp_valid <= 1'b0;
            case (state)
                RX_IDLE: begin
                    tmo_cnt <= '0;
                    bit_cnt <= '0;
                end
                RX_WAIT: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    bit_cnt <= '0;
                    if (tmo_hit) begin
                        rsp_valid   <= 1'b1;
                        rsp_data    <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                    end
                end
                RX_DATA: begin
                    shift   <= {shift[RSP_W-2:0], ret_q};
                    bit_cnt <= bit_cnt + 1'b1;
                end
                RX_PAR: begin
                    rsp_valid   <= 1'b1;
                    rsp_data    <= shift;
                    rsp_err     <= ^{shift, ret_q};
                    rsp_timeout <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/dtc_master_link.sv
// DTC master link: serialises L0/L1 triggers and 32-bit commands onto dtc_trig
// and hands command responses to the receiver sub-module.
module dtc_master_link
    import dtc_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int GAP     = 1
) (
    input  logic             rdoclk,
    input  logic             reset,
    input  logic             l0_req,
    input  logic             l1_req,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CMD_W-1:0] cmd_word,
    output logic             rsp_valid,
    output logic [RSP_W-1:0] rsp_data,
    output logic             rsp_err,
    output logic             rsp_timeout,
    output logic             trig_lost,
    output logic             dtc_trig,
    input  logic             dtc_return
);

    localparam int GAP_W = $clog2(GAP + 1);
    localparam int CNT_W = (GAP_W > 5) ? GAP_W : 5;

    tx_state_t        tx_state, tx_next;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       tx_type, sel_type;
    logic [CMD_W-1:0] tx_sh, cmd_reg;
    logic             tx_par, trig_next, start_sym;
    logic             l0_pend, l1_pend, cmd_held, cmd_busy;
    logic             any_pend, take_cmd, clr_l0, clr_l1, cmd_accept, lost_evt;

    assign any_pend   = l0_pend | l1_pend | cmd_held;
    assign sel_type   = l0_pend ? TYPE_L0 : (l1_pend ? TYPE_L1 : TYPE_CMD);
    assign clr_l0     = start_sym & l0_pend;
    assign clr_l1     = start_sym & ~l0_pend & l1_pend;
    assign take_cmd   = start_sym & ~l0_pend & ~l1_pend;
    assign cmd_ready  = ~reset & ~cmd_held & ~cmd_busy;
    assign cmd_accept = cmd_valid & cmd_ready;
    assign lost_evt   = (l0_req & l0_pend & ~clr_l0) | (l1_req & l1_pend & ~clr_l1);

    // trig_next is the bit that dtc_trig shows in the next cycle; the state names the bit on the line now.
    always_comb begin
        tx_next   = tx_state;
        trig_next = 1'b0;
        start_sym = 1'b0;
        case (tx_state)
            TX_IDLE: if (any_pend) start_sym = 1'b1;
            TX_HDR: begin
                if (cnt == CNT_W'(0))      trig_next = tx_type[1];
                else if (cnt == CNT_W'(1)) trig_next = tx_type[0];
                else if (tx_type == TYPE_CMD) begin
                    tx_next   = TX_PAYLOAD;
                    trig_next = tx_sh[CMD_W-1];
                end else begin
                    tx_next = TX_GAP;
                end
            end
            TX_PAYLOAD: begin
                if (cnt == CNT_W'(CMD_W - 1)) begin
                    tx_next   = TX_PARITY;
                    trig_next = tx_par;
                end else begin
                    trig_next = tx_sh[CMD_W-2];
                end
            end
            TX_PARITY: tx_next = TX_GAP;
            TX_GAP: begin
                if (cnt == CNT_W'(GAP - 1)) begin
                    if (any_pend) start_sym = 1'b1;
                    else          tx_next   = TX_IDLE;
                end
            end
            default: tx_next = TX_IDLE;
        endcase
        if (start_sym) begin
            tx_next   = TX_HDR;
            trig_next = 1'b1;
        end
    end

    always_ff @(posedge rdoclk) begin
        if (reset) begin
            tx_state  <= TX_IDLE;
            dtc_trig  <= 1'b0;
            cnt       <= '0;
            tx_type   <= TYPE_L0;
            tx_sh     <= '0;
            tx_par    <= 1'b0;
            cmd_reg   <= '0;
            l0_pend   <= 1'b0;
            l1_pend   <= 1'b0;
            cmd_held  <= 1'b0;
            cmd_busy  <= 1'b0;
            trig_lost <= 1'b0;
        end else begin
            tx_state <= tx_next;
            dtc_trig <= trig_next;
            cnt      <= (tx_next != tx_state) ? '0 : cnt + 1'b1;

            if (start_sym) begin
                tx_type <= sel_type;
                if (take_cmd) begin
                    tx_sh  <= cmd_reg;
                    tx_par <= ^cmd_reg;
                end
            end else if (tx_state == TX_PAYLOAD) begin
                tx_sh <= tx_sh << 1;
            end

            // A request in the same cycle its flag is consumed re-arms the flag instead of being lost.
            l0_pend <= (l0_pend & ~clr_l0) | l0_req;
            l1_pend <= (l1_pend & ~clr_l1) | l1_req;
            if (lost_evt) trig_lost <= 1'b1;

            cmd_held <= (cmd_held & ~take_cmd) | cmd_accept;
            if (cmd_accept) cmd_reg <= cmd_word;
            if (take_cmd)       cmd_busy <= 1'b1;
            else if (rsp_valid) cmd_busy <= 1'b0;
        end
    end

    dtc_master_rsp_rx #(
        .TIMEOUT(TIMEOUT)
    ) u_rsp_rx (
        .rdoclk     (rdoclk),
        .reset      (reset),
        .start      (tx_state == TX_PARITY),
        .dtc_return (dtc_return),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout)
    );

endmodule

// File: tb/tb_dtc_master_link.sv
// Directed bench for dtc_master_link: decodes dtc_trig symbols, models the slave
// response on dtc_return and checks outputs at hand-computed cycles.
module tb_dtc_master_link;

    localparam int TIMEOUT = 40;
    localparam int GAP     = 2;

    typedef struct {
        int          start;
        logic [1:0]  typ;
        logic [31:0] payload;
        logic        par;
    } sym_t;

    typedef struct {
        int          cyc;
        logic [15:0] data;
        logic        err;
        logic        tmo;
    } rsp_t;

    logic        rdoclk, reset, l0_req, l1_req, cmd_valid, cmd_ready;
    logic [31:0] cmd_word;
    logic        rsp_valid, rsp_err, rsp_timeout, trig_lost, dtc_trig, dtc_return;
    logic [15:0] rsp_data;

    int checkCount = 0;
    int passCount  = 0;
    int cyc        = 0;

    sym_t sym_q[$];
    rsp_t rsp_q[$];

    bit          slave_en    = 1'b0;
    logic [15:0] slave_data  = '0;
    bit          slave_flip  = 1'b0;
    int          slave_delay = 0;
    int          resp_start  = -100;
    logic [17:0] resp_bits   = '0;

    bit          dec_active = 1'b0;
    int          dec_n      = 0;
    int          dec_start  = 0;
    logic [34:0] dec_bits   = '0;

    dtc_master_link #(
        .TIMEOUT(TIMEOUT),
        .GAP    (GAP)
    ) dut (
        .rdoclk     (rdoclk),
        .reset      (reset),
        .l0_req     (l0_req),
        .l1_req     (l1_req),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_word   (cmd_word),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .trig_lost  (trig_lost),
        .dtc_trig   (dtc_trig),
        .dtc_return (dtc_return)
    );

    initial begin
        rdoclk = 1'b0;
        forever #5 rdoclk = ~rdoclk;
    end

    // Symbol decoder and response logger; they see the values held during the cycle just ended.
    always @(posedge rdoclk) begin
        sym_t s;
        rsp_t r;
        cyc <= cyc + 1;
        if (rsp_valid && !reset) begin
            r.cyc  = cyc;
            r.data = rsp_data;
            r.err  = rsp_err;
            r.tmo  = rsp_timeout;
            rsp_q.push_back(r);
        end
        if (reset) begin
            dec_active = 1'b0;
            resp_start = -100;
        end else if (!dec_active) begin
            if (dtc_trig) begin
                dec_active = 1'b1;
                dec_start  = cyc;
                dec_n      = 0;
                dec_bits   = '0;
            end
        end else begin
            dec_bits = {dec_bits[33:0], dtc_trig};
            dec_n++;
            if (dec_n == 2 && dec_bits[1:0] != 2'b10) begin
                s.start = dec_start; s.typ = dec_bits[1:0]; s.payload = '0; s.par = 1'b0;
                sym_q.push_back(s);
                dec_active = 1'b0;
            end else if (dec_n == 35) begin
                s.start = dec_start; s.typ = dec_bits[34:33];
                s.payload = dec_bits[32:1]; s.par = dec_bits[0];
                sym_q.push_back(s);
                dec_active = 1'b0;
                if (slave_en) begin
                    resp_start = cyc + 1 + slave_delay;
                    resp_bits  = {1'b1, slave_data, (^slave_data) ^ slave_flip};
                end
            end
        end
    end

    initial begin
        dtc_return = 1'b0;
        forever begin
            @(negedge rdoclk);
            if (cyc >= resp_start && cyc < resp_start + 18)
                dtc_return = resp_bits[17 - (cyc - resp_start)];
            else
                dtc_return = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic waitTo(input int target);
        while (cyc < target) @(negedge rdoclk);
    endtask

    task automatic applyStimulus(input logic l0, input logic l1, input logic cv,
                                 input logic [31:0] word, output int reqCyc);
        reqCyc    = cyc;
        l0_req    = l0;
        l1_req    = l1;
        cmd_valid = cv;
        cmd_word  = word;
        @(negedge rdoclk);
        l0_req    = 1'b0;
        l1_req    = 1'b0;
        cmd_valid = 1'b0;
        cmd_word  = '0;
    endtask

    task automatic checkSym(input string tag, input int idx, input logic [1:0] typ, input int start);
        if (idx < sym_q.size()) begin
            checkOutput({tag, " type"}, 32'(sym_q[idx].typ), 32'(typ));
            checkOutput({tag, " start"}, sym_q[idx].start, start);
        end
    endtask

    initial begin
        int r, c;
        logic [4:0] expL0;
        logic [3:0] expHdr;

        reset = 1'b1; l0_req = 1'b0; l1_req = 1'b0; cmd_valid = 1'b0; cmd_word = '0;
        repeat (3) @(negedge rdoclk);
        checkOutput("reset dtc_trig", dtc_trig, 0);
        checkOutput("reset cmd_ready", cmd_ready, 0);
        checkOutput("reset rsp_valid", rsp_valid, 0);
        checkOutput("reset rsp_data", rsp_data, 0);
        checkOutput("reset rsp_err", rsp_err, 0);
        checkOutput("reset rsp_timeout", rsp_timeout, 0);
        checkOutput("reset trig_lost", trig_lost, 0);
        reset = 1'b0;
        @(negedge rdoclk);
        checkOutput("ready after reset", cmd_ready, 1);

        // L0 from idle: 1,0,0 two cycles after the request, then idle zeros.
        sym_q.delete();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, r);
        checkOutput("l0 pre", dtc_trig, 0);
        expL0 = 5'b10000;
        for (int k = 0; k < 5; k++) begin
            waitTo(r + 2 + k);
            checkOutput($sformatf("l0 bit %0d", k), dtc_trig, expL0[4-k]);
        end
        checkOutput("l0 sym count", sym_q.size(), 1);
        checkSym("l0 sym", 0, 2'b00, r + 2);

        // Read command; slave answers 16'hBEEF with its even-parity bit (1).
        sym_q.delete(); rsp_q.delete();
        slave_en = 1'b1; slave_data = 16'hBEEF; slave_flip = 1'b0; slave_delay = 3;
        waitTo(cyc + 2);
        checkOutput("cmd ready idle", cmd_ready, 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h8012_0000, r);
        c = r + 2;
        expHdr = 4'b1101;
        for (int k = 0; k < 4; k++) begin
            waitTo(c + k);
            checkOutput($sformatf("cmd hdr bit %0d", k), dtc_trig, expHdr[3-k]);
        end
        checkOutput("cmd ready busy", cmd_ready, 0);
        waitTo(c + 58);
        checkOutput("beef rsp_valid", rsp_valid, 1);
        checkOutput("beef rsp_data", rsp_data, 32'hBEEF);
        checkOutput("beef rsp_err", rsp_err, 0);
        checkOutput("beef rsp_timeout", rsp_timeout, 0);
        checkOutput("beef ready at rsp", cmd_ready, 0);
        waitTo(c + 59);
        checkOutput("beef rsp_valid end", rsp_valid, 0);
        checkOutput("beef ready back", cmd_ready, 1);
        checkOutput("beef rsp count", rsp_q.size(), 1);
        checkOutput("beef sym count", sym_q.size(), 1);
        if (sym_q.size() > 0) begin
            checkSym("beef sym", 0, 2'b10, c);
            checkOutput("beef payload", sym_q[0].payload, 32'h8012_0000);
            checkOutput("beef cmd parity", sym_q[0].par, 1);
        end

        // Timeout: no start bit, pulse TIMEOUT+1 cycles after entering WAIT.
        rsp_q.delete();
        slave_en = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0003_0000, r);
        c = r + 2;
        waitTo(c + 76);
        checkOutput("tmo early", rsp_valid, 0);
        waitTo(c + 77);
        checkOutput("tmo rsp_valid", rsp_valid, 1);
        checkOutput("tmo rsp_data", rsp_data, 0);
        checkOutput("tmo rsp_err", rsp_err, 1);
        checkOutput("tmo rsp_timeout", rsp_timeout, 1);
        waitTo(c + 78);
        checkOutput("tmo ready back", cmd_ready, 1);

        // Bad parity on the latest allowed start bit.
        rsp_q.delete();
        slave_en = 1'b1; slave_data = 16'h0001; slave_flip = 1'b1; slave_delay = TIMEOUT - 1;
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h8001_0000, r);
        c = r + 2;
        waitTo(c + 94);
        checkOutput("par rsp_valid", rsp_valid, 1);
        checkOutput("par rsp_data", rsp_data, 32'h0001);
        checkOutput("par rsp_err", rsp_err, 1);
        checkOutput("par rsp_timeout", rsp_timeout, 0);
        waitTo(c + 96);

        // L0, L1 and command in the same cycle go out as L0, L1, CMD.
        sym_q.delete(); rsp_q.delete();
        slave_en = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_1234, r);
        waitTo(r + 90);
        checkOutput("order sym count", sym_q.size(), 3);
        checkSym("order l0", 0, 2'b00, r + 2);
        checkSym("order l1", 1, 2'b01, r + 7);
        checkSym("order cmd", 2, 2'b10, r + 12);
        checkOutput("order rsp count", rsp_q.size(), 1);
        if (rsp_q.size() > 0) begin
            checkOutput("order rsp cycle", rsp_q[0].cyc, r + 89);
            checkOutput("order rsp tmo", rsp_q[0].tmo, 1);
        end
        checkOutput("order no lost", trig_lost, 0);

        // Two L1 requests during a command payload: one L1 symbol, trig_lost set.
        sym_q.delete(); rsp_q.delete();
        slave_en = 1'b1; slave_data = 16'h1234; slave_flip = 1'b0; slave_delay = 0;
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0055_AAAA, r);
        c = r + 2;
        waitTo(c + 10);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, r);
        checkOutput("lost before", trig_lost, 0);
        waitTo(c + 20);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, r);
        waitTo(c + 22);
        checkOutput("lost after", trig_lost, 1);
        waitTo(c + 60);
        checkOutput("lost sym count", sym_q.size(), 2);
        checkSym("lost l1", 1, 2'b01, c + 36 + GAP);
        checkOutput("lost rsp count", rsp_q.size(), 1);
        if (rsp_q.size() > 0) begin
            checkOutput("lost rsp cycle", rsp_q[0].cyc, c + 55);
            checkOutput("lost rsp data", rsp_q[0].data, 32'h1234);
            checkOutput("lost rsp err", rsp_q[0].err, 0);
        end

        // Reset at payload bit 10 aborts the symbol and the response.
        sym_q.delete(); rsp_q.delete();
        slave_data = 16'h5555;
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, r);
        c = r + 2;
        waitTo(c + 13);
        checkOutput("rst payload bit10", dtc_trig, 1);
        reset = 1'b1;
        waitTo(c + 14);
        checkOutput("rst dtc_trig", dtc_trig, 0);
        checkOutput("rst cmd_ready", cmd_ready, 0);
        checkOutput("rst trig_lost", trig_lost, 0);
        waitTo(c + 15);
        reset = 1'b0;
        waitTo(c + 16);
        checkOutput("rst ready back", cmd_ready, 1);
        waitTo(c + 100);
        checkOutput("rst line idle", dtc_trig, 0);
        checkOutput("rst no rsp", rsp_q.size(), 0);
        checkOutput("rst no sym", sym_q.size(), 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
